// File: rtl/booth_multiplier_16x16.sv
// rtl/booth_multiplier_16x16.sv - sequential 16x16 signed radix-2 Booth multiplier
module booth_multiplier_16x16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        ld,
  input  logic        ld_pp,
  output logic        ld_p,
  output logic [31:0] product
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [15:0] m;
  logic [15:0] q;
  logic [15:0] a;
  logic        qm1;
  logic [4:0]  cnt;
  logic [16:0] sum;

  // Sum is kept one bit wider so the bit shifted into A is the true sign,
  // which keeps M = -32768 exact when it is subtracted.
  always_comb begin
    sum = {a[15], a};
    case ({q[0], qm1})
      2'b01:   sum = {a[15], a} + {m[15], m};
      2'b10:   sum = {a[15], a} - {m[15], m};
      default: sum = {a[15], a};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      m       <= 16'd0;
      q       <= 16'd0;
      a       <= 16'd0;
      qm1     <= 1'b0;
      cnt     <= 5'd0;
      product <= 32'd0;
      ld_p    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ld_p <= 1'b0;
          if (ld) begin
            m <= in_a;
            q <= in_b;
          end else if (ld_pp) begin
            a     <= 16'd0;
            qm1   <= 1'b0;
            cnt   <= 5'd16;
            state <= RUN;
          end
        end
        RUN: begin
          if (cnt != 5'd0) begin
            {a, q, qm1} <= {sum, q};
            cnt         <= cnt - 5'd1;
          end else begin
            product <= {a, q};
            ld_p    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          ld_p  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ld_p  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier_16x16.sv
// tb/tb_booth_multiplier_16x16.sv - scoreboard bench for booth_multiplier_16x16
module tb_booth_multiplier_16x16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in_a = 16'd0;
  logic [15:0] in_b = 16'd0;
  logic        ld = 1'b0;
  logic        ld_pp = 1'b0;
  logic        ld_p;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  logic        prev_ld_p = 1'b0;
  logic [31:0] last_product = 32'd0;

  booth_multiplier_16x16 dut (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b),
    .ld(ld), .ld_pp(ld_pp), .ld_p(ld_p), .product(product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every ld_p and checks hold after the pulse.
  always @(negedge clk) begin
    if (ld_p) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ld_p: got product %h with no multiply outstanding", product);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++;
        if (product !== e) begin
          errors++;
          $display("FAIL product: got %h expected %h", product, e);
        end
      end
    end
    if (prev_ld_p && !ld_p) begin
      checks++;
      if (product !== last_product) begin
        errors++;
        $display("FAIL product_hold: got %h expected %h", product, last_product);
      end
    end
    prev_ld_p    = ld_p;
    last_product = product;
  end

  // mode 0: plain multiply; 1: ld/ld_pp disturbance during RUN; 2: reset at S+8
  task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input int mode);
    logic [31:0] p;
    int s;
    bit seen;
    p = $signed(a) * $signed(b);
    if (mode != 2) exp_q.push_back(p);
    @(posedge clk); #1;
    in_a = a; in_b = b; ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    @(posedge clk); #1;
    ld_pp = 1'b1;
    @(posedge clk); #1;
    ld_pp = 1'b0;
    s = cyc;
    if (mode == 2) begin
      repeat (7) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      check32("abort_ld_p", {31'd0, ld_p}, 32'd0);
      check32("abort_product", product, 32'd0);
      repeat (25) @(posedge clk);
      #1 check32("abort_product_later", product, 32'd0);
      return;
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mode == 1 && cyc == s + 5) begin
        in_a = 16'h1234; in_b = 16'h0777; ld = 1'b1; ld_pp = 1'b1;
      end
      if (mode == 1 && cyc == s + 7) begin
        ld = 1'b0; ld_pp = 1'b0;
      end
      @(posedge clk); #1;
      if (ld_p) begin
        seen = 1'b1;
        break;
      end
    end
    ld = 1'b0; ld_pp = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ld_p_timeout: got no ld_p within 40 cycles, expected one");
    end else begin
      check32("latency", 32'(cyc - s), 32'd17);
      @(posedge clk); #1;
      check32("ld_p_width", {31'd0, ld_p}, 32'd0);
      check32("product_after_fall", product, p);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check32("reset_product", product, 32'd0);
    check32("reset_ld_p", {31'd0, ld_p}, 32'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check32("idle_product", product, 32'd0);
    check32("idle_ld_p", {31'd0, ld_p}, 32'd0);

    do_mul(16'd3, 16'd5, 0);
    do_mul(16'hFFFF, 16'd1, 0);
    do_mul(16'h8000, 16'h8000, 0);
    do_mul(16'h8000, 16'h7FFF, 0);
    do_mul(16'h7FFF, 16'h7FFF, 0);
    for (int i = 0; i < 5; i++)
      do_mul(16'($urandom_range(0, 32767)), 16'($urandom_range(0, 32767)), 0);
    do_mul(16'd0, 16'($urandom_range(1, 65535)), 0);
    for (int i = 0; i < 6; i++)
      do_mul(16'($urandom), 16'($urandom), 0);
    do_mul(16'd1234, 16'hFF85, 1);
    do_mul(16'h4321, 16'h0456, 2);
    do_mul(16'hF00D, 16'h0BEE, 0);

    repeat (5) @(posedge clk);
    #1;
    check32("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
